// File: rtl/regfile_pkg.sv
// Shared widths and read-sequencer state encoding for the register-file access controller.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_READ = 2'd1,
    R_RSP  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Arbitrates decode operand reads against writeback writes onto a 2R/1W register file.
// Optional RF_BYPASS_EN: writes granted while a read is in flight patch the held operands.
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned MAX_WR_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_data1,
  output logic [XLEN-1:0]       rsp_data2,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic [REG_ADDR_W-1:0] rf_read_address1,
  output logic [REG_ADDR_W-1:0] rf_read_address2,
  output logic [REG_ADDR_W-1:0] rf_write_address,
  output logic [XLEN-1:0]       rf_write_data,
  output logic                  rf_write_enable,
  input  logic [XLEN-1:0]       rf_read_data1,
  input  logic [XLEN-1:0]       rf_read_data2
);

  localparam int unsigned STREAK_W = $clog2(MAX_WR_STREAK + 1);

  rd_state_t             state_q;
  logic [STREAK_W-1:0]   streak_q;
  logic [REG_ADDR_W-1:0] addr1_q, addr2_q;
  logic [XLEN-1:0]       data1_q, data2_q;

  logic can_accept, streak_full, write_grant, issue, hit1, hit2;

  // Writes win unless a starved read has hit the streak limit.
  assign can_accept  = !reset && ((state_q == R_IDLE) || ((state_q == R_RSP) && rsp_ready));
  assign streak_full = (streak_q == STREAK_W'(MAX_WR_STREAK));
  assign wr_ready    = !reset && !(rd_req_valid && can_accept && streak_full);
  assign write_grant = wr_valid && wr_ready;
  assign rd_req_ready = can_accept && !write_grant;
  assign issue       = rd_req_valid && rd_req_ready;

  assign rf_write_enable  = write_grant;
  assign rf_write_address = wr_addr;
  assign rf_write_data    = wr_data;
  assign rf_read_address1 = issue ? rd_addr1 : addr1_q;
  assign rf_read_address2 = issue ? rd_addr2 : addr2_q;

  assign rsp_valid = (state_q == R_RSP);
  assign rsp_data1 = data1_q;
  assign rsp_data2 = data2_q;

`ifdef RF_BYPASS_EN
  assign hit1 = write_grant && (addr1_q != '0) && (wr_addr == addr1_q);
  assign hit2 = write_grant && (addr2_q != '0) && (wr_addr == addr2_q);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= R_IDLE;
      streak_q <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      case (state_q)
        R_IDLE: if (issue) state_q <= R_READ;
        R_READ: begin
          state_q <= R_RSP;
          data1_q <= (addr1_q == '0) ? '0 : (hit1 ? wr_data : rf_read_data1);
          data2_q <= (addr2_q == '0) ? '0 : (hit2 ? wr_data : rf_read_data2);
        end
        R_RSP: begin
          if (rsp_ready) begin
            state_q <= issue ? R_READ : R_IDLE;
          end else begin
            if (hit1) data1_q <= wr_data;
            if (hit2) data2_q <= wr_data;
          end
        end
        default: state_q <= R_IDLE;
      endcase

      if (issue) begin
        addr1_q <= rd_addr1;
        addr2_q <= rd_addr2;
      end

      // Counts consecutive writes that kept an acceptable read waiting.
      if (issue || !rd_req_valid)
        streak_q <= '0;
      else if (write_grant && can_accept && !streak_full)
        streak_q <= streak_q + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a transaction-level reference model.
module tb_regfile_access_ctrl;
  import regfile_pkg::*;

  localparam int unsigned MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data1, rsp_data2;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rf_read_address1, rf_read_address2, rf_write_address;
  logic [31:0] rf_write_data;
  logic        rf_write_enable;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        tb_load;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  regfile_access_ctrl #(.MAX_WR_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_read_address1(rf_read_address1), .rf_read_address2(rf_read_address2),
    .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    if (i == 3) return 32'h11;
    if (i == 5) return 32'h1;
    return 32'h100 + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // External register file: synchronous reads, suppressed in write cycles.
  logic [31:0] rfm [32];
  always @(posedge clk) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) rfm[i] <= init_val(i);
      rf_read_data1 <= '0;
      rf_read_data2 <= '0;
    end else if (rf_write_enable) begin
      rfm[rf_write_address] <= rf_write_data;
    end else begin
      rf_read_data1 <= rfm[rf_read_address1];
      rf_read_data2 <= rfm[rf_read_address2];
    end
  end

  // Reference model: architectural register values plus one outstanding read.
  logic [31:0] arch [32];
  int          m_phase;   // 0 none, 1 awaiting capture, 2 response presented
  int          m_streak;
  logic [4:0]  m_h1, m_h2;
  logic [31:0] m_v1, m_v2;
  bit          m_acc, m_ewr, m_wg, m_erd, m_iss;

  initial forever begin
    @(negedge clk);
    if (tb_load) begin
      for (int i = 0; i < 32; i++) arch[i] = init_val(i);
      m_phase = 0; m_streak = 0; m_h1 = '0; m_h2 = '0; m_v1 = '0; m_v2 = '0;
    end else if (reset) begin
      m_phase = 0; m_streak = 0; m_h1 = '0; m_h2 = '0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rd_req_ready", 32'(rd_req_ready), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_rf_we", 32'(rf_write_enable), 32'd0);
    end else begin
      m_acc = (m_phase == 0) || (m_phase == 2 && rsp_ready);
      m_ewr = !(rd_req_valid && m_acc && m_streak == int'(MAXS));
      m_wg  = wr_valid && m_ewr;
      m_erd = m_acc && !m_wg;
      m_iss = rd_req_valid && m_erd;
      chk("m_wr_ready", 32'(wr_ready), 32'(m_ewr));
      chk("m_rd_req_ready", 32'(rd_req_ready), 32'(m_erd));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("m_rsp_data1", rsp_data1, m_v1);
        chk("m_rsp_data2", rsp_data2, m_v2);
      end
      chk("m_rf_raddr1", 32'(rf_read_address1), 32'(m_iss ? rd_addr1 : m_h1));
      chk("m_rf_raddr2", 32'(rf_read_address2), 32'(m_iss ? rd_addr2 : m_h2));
      chk("m_rf_we", 32'(rf_write_enable), 32'(m_wg));
      if (m_wg) begin
        chk("m_rf_waddr", 32'(rf_write_address), 32'(wr_addr));
        chk("m_rf_wdata", rf_write_data, wr_data);
      end
`ifdef RF_BYPASS_EN
      if (m_wg && (m_phase == 1 || m_phase == 2)) begin
        if (m_h1 != 0 && m_h1 == wr_addr) m_v1 = wr_data;
        if (m_h2 != 0 && m_h2 == wr_addr) m_v2 = wr_data;
      end
`endif
      if (m_phase == 1) m_phase = 2;
      else if (m_phase == 2 && rsp_ready) m_phase = 0;
      if (m_iss) begin
        m_h1 = rd_addr1; m_h2 = rd_addr2;
        m_v1 = (rd_addr1 == 0) ? 32'd0 : arch[rd_addr1];
        m_v2 = (rd_addr2 == 0) ? 32'd0 : arch[rd_addr2];
        m_phase = 1;
      end
      if (m_iss || !rd_req_valid) m_streak = 0;
      else if (m_wg && m_acc && m_streak < int'(MAXS)) m_streak++;
      if (m_wg) arch[wr_addr] = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a read until accepted; returns the accept cycle.
  task automatic issue_read(input logic [4:0] a1, input logic [4:0] a2, output int acc);
    bit got = 0;
    acc = 0;
    rd_req_valid = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_req_ready) begin got = 1; acc = cyc; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    rd_req_valid = 1'b0;
  endtask

  // Leaves the caller at the negedge where rsp_valid is seen.
  task automatic wait_rsp(output int at);
    bit got = 0;
    at = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; at = cyc; end
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  int n, t;

  initial begin
    reset = 1'b1; tb_load = 1'b1;
    rd_req_valid = 0; rd_addr1 = 0; rd_addr2 = 0; rsp_ready = 0;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    repeat (2) @(posedge clk);
    #1 tb_load = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // 1: read x3/x0, two-cycle latency
    rsp_ready = 1'b1;
    issue_read(5'd3, 5'd0, n);
    wait_rsp(t);
    chk("s1_latency", 32'(t - n), 32'd2);
    chk("s1_data1", rsp_data1, 32'h11);
    chk("s1_data2", rsp_data2, 32'h0);
    tick();

    // 2: write streak starves a read for exactly MAXS grants
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'hA000;
    rd_req_valid = 1'b1; rd_addr1 = 5'd8; rd_addr2 = 5'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s2_wr_ready", 32'(wr_ready), (i == 4) ? 32'd0 : 32'd1);
      chk("s2_rd_req_ready", 32'(rd_req_ready), (i == 4) ? 32'd1 : 32'd0);
      tick();
      wr_data = wr_data + 32'd1;
      if (i == 4) rd_req_valid = 1'b0;
    end
    wr_valid = 1'b0;
    wait_rsp(t);
    chk("s2_data1", rsp_data1, 32'h108);
    chk("s2_data2", rsp_data2, 32'h109);
    tick();

    // 3: backpressure holds response and read addresses
    rsp_ready = 1'b0;
    issue_read(5'd1, 5'd2, n);
    wait_rsp(t);
    tick();
    rd_req_valid = 1'b1; rd_addr1 = 5'd4; rd_addr2 = 5'd6;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s3_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("s3_data1", rsp_data1, 32'h101);
      chk("s3_data2", rsp_data2, 32'h102);
      chk("s3_rd_req_ready", 32'(rd_req_ready), 32'd0);
      chk("s3_raddr1", 32'(rf_read_address1), 32'd1);
      chk("s3_raddr2", 32'(rf_read_address2), 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("s3_back2back_accept", 32'(rd_req_ready), 32'd1);
    n = cyc;
    tick();
    rd_req_valid = 1'b0;
    wait_rsp(t);
    chk("s3_b2b_latency", 32'(t - n), 32'd2);
    chk("s3_b2b_data1", rsp_data1, 32'h104);
    chk("s3_b2b_data2", rsp_data2, 32'h106);
    tick();

    // 4: write to a held operand while the response waits
    rsp_ready = 1'b0;
    issue_read(5'd5, 5'd3, n);
    wait_rsp(t);
    tick();
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hAA;
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("s4_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef RF_BYPASS_EN
    chk("s4_data1", rsp_data1, 32'hAA);
`else
    chk("s4_data1", rsp_data1, 32'h1);
`endif
    chk("s4_data2", rsp_data2, 32'h11);
    tick();
    rsp_ready = 1'b1;
    tick();

    // 5: x0 always reads zero, never forwarded
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'hFF;
    tick();
    wr_valid = 1'b0; rsp_ready = 1'b0;
    issue_read(5'd0, 5'd0, n);
    wait_rsp(t);
    chk("s5_data1", rsp_data1, 32'h0);
    tick();
    wr_valid = 1'b1; wr_addr = 5'd0; wr_data = 32'h55;
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("s5_nofwd_data1", rsp_data1, 32'h0);
    chk("s5_nofwd_data2", rsp_data2, 32'h0);
    tick();
    rsp_ready = 1'b1;
    tick();

    // 6: reset while a read is being captured
    issue_read(5'd3, 5'd5, n);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s6_no_stale_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    issue_read(5'd3, 5'd5, n);
    wait_rsp(t);
    chk("s6_latency", 32'(t - n), 32'd2);
    chk("s6_data1", rsp_data1, 32'h11);
    chk("s6_data2", rsp_data2, 32'hAA);
    tick();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
